turn_signal_scheduler: RTL

Sequencing and arbitration controller for the six Thunderbird tail lamps (three per side). It takes the driver's left, right, hazard and brake requests and picks which lamp pattern owns the lamps. It paces each pattern with an internal step prescaler and drives registered lamp outputs. It sits between the switch-debounce logic and the lamp drivers, and replaces the free-running sequential controller as the single owner of la..rc.

---
 rtl/turn_signal_scheduler_if.sv | 25 ++
 rtl/turn_signal_scheduler.sv | 113 +++++++++++
 2 files changed

// File: rtl/turn_signal_scheduler_if.sv
// Request and lamp bundle between the switch debounce logic and the tail-lamp drivers.
// The master side drives requests and watches lamps; the slave side is the scheduler.
interface turn_signal_scheduler_if;
  logic left;
  logic right;
  logic hazard;
  logic brake;
  logic la;
  logic lb;
  logic lc;
  logic ra;
  logic rb;
  logic rc;
  logic busy;

  modport master (
    output left, right, hazard, brake,
    input  la, lb, lc, ra, rb, rc, busy
  );

  modport slave (
    input  left, right, hazard, brake,
    output la, lb, lc, ra, rb, rc, busy
  );
endinterface

// File: rtl/turn_signal_scheduler.sv
// Thunderbird tail-lamp scheduler: arbitrates left/right/hazard requests, paces the
// chosen pattern with a step prescaler and overlays brake on lamps not owned by a turn.
module turn_signal_scheduler #(
  parameter int unsigned TICK_DIV = 4
) (
  input logic                     clk,
  input logic                     reset,
  turn_signal_scheduler_if.slave  bus
);

  typedef enum logic [3:0] {
    StIdle, StL1, StL2, StL3, StR1, StR2, StR3, StGap, StHzOn, StHzOff
  } state_e;

  localparam logic [7:0] CntMax = 8'(TICK_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  lamp_l_q, lamp_l_d;
  logic [2:0]  lamp_r_q, lamp_r_d;
  logic        busy_q;
  logic        tick;
  logic [1:0]  rst_sync_q;
  logic        rst_int_n;

  // Assertion passes straight through; release is retimed to clk over two flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];
  assign tick      = (cnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == StIdle || tick) ? 8'd0 : cnt_q + 8'd1;
    if (state_q == StIdle) begin
      if (bus.hazard || (bus.left && bus.right)) begin
        state_d = StHzOn;
      end else if (bus.left) begin
        state_d = StL1;
      end else if (bus.right) begin
        state_d = StR1;
      end
    end else if (tick) begin
      case (state_q)
        StL1:    state_d = StL2;
        StL2:    state_d = StL3;
        StL3:    state_d = StGap;
        StR1:    state_d = StR2;
        StR2:    state_d = StR3;
        StR3:    state_d = StGap;
        StHzOn:  state_d = StHzOff;
        default: state_d = StIdle;
      endcase
      // Hazard may cut into a turn or its gap, but never into its own on/off pair.
      if (bus.hazard && state_q != StHzOn && state_q != StHzOff) begin
        state_d = StHzOn;
      end
    end
  end

  always_comb begin
    lamp_l_d = {3{bus.brake}};
    lamp_r_d = {3{bus.brake}};
    case (state_d)
      StL1:    lamp_l_d = 3'b100;
      StL2:    lamp_l_d = 3'b110;
      StL3:    lamp_l_d = 3'b111;
      StR1:    lamp_r_d = 3'b100;
      StR2:    lamp_r_d = 3'b110;
      StR3:    lamp_r_d = 3'b111;
      StHzOn: begin
        lamp_l_d = 3'b111;
        lamp_r_d = 3'b111;
      end
      StHzOff: begin
        lamp_l_d = 3'b000;
        lamp_r_d = 3'b000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      lamp_l_q <= 3'b000;
      lamp_r_q <= 3'b000;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lamp_l_q <= lamp_l_d;
      lamp_r_q <= lamp_r_d;
      busy_q   <= (state_d != StIdle);
    end
  end

  assign bus.la   = lamp_l_q[2];
  assign bus.lb   = lamp_l_q[1];
  assign bus.lc   = lamp_l_q[0];
  assign bus.ra   = lamp_r_q[2];
  assign bus.rb   = lamp_r_q[1];
  assign bus.rc   = lamp_r_q[0];
  assign bus.busy = busy_q;

endmodule
